serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder. Loads two operands, then adds them LSB-first, one bit per clock, through a single full-adder cell with a registered carry.
- Produces an N-bit sum plus carry-out with a start/busy/done handshake.
- Sits in the arithmetic datapath as the sequential stage built on the team's one-bit adder cells. Trades latency for minimal adder area.

Parameters:
WIDTH, 8, operand and sum width in bits (≥2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured when start accepted
b  input  WIDTH  operand B, captured when start accepted
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse; sum/carry_out valid
sum  output  WIDTH  result, held until next accepted start
carry_out  output  1  final carry, held with sum

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, sum=0, carry_out=0; internal shift regs, carry and counter cleared. Reset mid-operation aborts the add with no done pulse.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE (Moore).
- IDLE:
  - start=1 at edge k: capture a and b into shift regs, carry reg=0, counter=0, go to SHIFT.
  - start=0: stay in IDLE; outputs held.
- SHIFT, each edge:
  - s = a_sh[0] ^ b_sh[0] ^ c; c_next = majority(a_sh[0], b_sh[0], c).
  - Result reg shifts right with s inserted at MSB; a_sh and b_sh shift right with 0 fill; c <= c_next; counter++.
  - At counter==WIDTH-1: go to DONE. Result reg then holds the full sum; carry_out <= c_next.
- Timing: exactly WIDTH cycles in SHIFT. done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after start is sampled. DONE lasts one cycle, then IDLE.
- sum: driven from the result reg only on entry to DONE. Intermediate shifting is not visible on sum, which holds the previous result while busy.
- start while busy or in DONE: ignored; no queuing. Back-to-back: start asserted the cycle after done is accepted.
- a and b changes after capture have no effect.
- Arithmetic is modulo 2^WIDTH; carry_out is unsigned overflow.
- Counter width: clog2(WIDTH); no wrap within an operation.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1: operand B is captured bit-inverted and carry reg initialised to 1, giving A-B in two's complement. carry_out=1 means no borrow.
  - sub=0: identical to the add path.
- Undefined: no sub port; add only.
- Latency is identical in both builds.

Decomposition:
- Package serial_adder_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Function/localparam for counter width = clog2(WIDTH).
- Sub-module full_adder_cell: one-bit combinational sum/carry (a, b, cin -> s, cout), instantiated once in the SHIFT datapath.
- The FSM and shift registers stay in serial_adder.

Test Plan:
WIDTH=8 throughout.
- Basic add: a=0x0F, b=0x01, start pulse -> busy for 8 cycles; done at cycle 9; sum=0x10, carry_out=0.
- Overflow: a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0x80, b=0x80 -> sum=0x00, carry_out=1.
- Start while busy: second start with a=0x11, b=0x22 asserted at cycle 3 -> ignored; result of the first op unchanged; exactly one done pulse.
- Reset mid-op: assert rst at cycle 4 of SHIFT -> next cycle state IDLE, all outputs 0, no done. A new start then completes normally: 0x05+0x03=0x08.
- Back-to-back and hold: 0xAA+0x55 -> 0xFF, co=0. Start next cycle with 0x01+0x01 -> sum holds 0xFF throughout busy, then becomes 0x02.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07 -> sum=0xFE, carry_out=0. sub=1, a=0x07, b=0x05 -> sum=0x02, carry_out=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=2.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder used as the shared arithmetic cell of the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first through one full-adder cell with registered carry.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting A-B (carry_out=1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c),
    .s    (s_bit),
    .cout (c_next)
  );

  // The new bit enters at the MSB; after WIDTH shifts the full sum is aligned.
  assign res_next = {s_bit, res_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
`ifdef SERIAL_ADDER_SUB_EN
            b_sh  <= sub ? ~b : b;
            c     <= sub;
`else
            b_sh  <= b;
            c     <= 1'b0;
`endif
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res_sh <= res_next[WIDTH-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c      <= c_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum       <= res_next;
            carry_out <= c_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  int               tests = 0;
  int               fails = 0;
  int               done_cnt = 0;
  logic [WIDTH-1:0] held_sum = '0;
  logic             held_co = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic osub, input bit inject);
    logic [WIDTH-1:0] exp_sum;
    logic             exp_co;
    int               d0;
    if (osub) begin
      exp_sum = oa - ob;
      exp_co  = (oa >= ob);
    end else begin
      {exp_co, exp_sum} = {1'b0, oa} + {1'b0, ob};
    end
    a = oa; b = ob; sub = osub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    for (int j = 0; j < WIDTH; j++) begin
      chk("busy_high", busy, 1);
      chk("done_low_busy", done, 0);
      chk("sum_held", sum, held_sum);
      chk("co_held", carry_out, held_co);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      sub = 1'($urandom);
      if (inject && j == 2) begin
        a = 8'h11; b = 8'h22; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("sum", sum, exp_sum);
    chk("carry_out", carry_out, exp_co);
    held_sum = exp_sum;
    held_co  = exp_co;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_after", sum, held_sum);
    chk("done_count", done_cnt - d0, 1);
  endtask

  task automatic reset_mid_op();
    int d0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", carry_out, 0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (WIDTH + 2) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle_busy", busy, 0);
    held_sum = '0;
    held_co  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_co", carry_out, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h0F, 8'h01, 1'b0, 1'b1);
    reset_mid_op();
    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    run_op(8'hAA, 8'h55, 1'b0, 1'b0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b0);
    run_op(8'h07, 8'h05, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), (i % 5) == 0);
`else
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b0, (i % 5) == 0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
